// File: rtl/manchester_decoder.sv
// Manchester line decoder.
// Recovers the bit stream from an asynchronous Manchester-coded data line.
// Each frame opens with a '1' start bit. The high half of that bit sets the
// half-bit length H that every later threshold is derived from. A mid-bit
// transition yields one strobe carrying the level seen just before the edge.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | line idle, waiting for the rising edge of a start bit
// ST_MEASURE | counting the high half of the start bit to learn H
// ST_DATA    | decoding bits; a mid-bit edge is one at or beyond 1.5*H
module manchester_decoder #(
  parameter int CNT_W    = 7,
  parameter int MIN_HALF = 2,
  parameter int MAX_HALF = 31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_line,
  output logic       out_data,
  output logic       out_strobe,
  output logic [5:0] out_pulsewidth,
  output logic       out_active,
  output logic       out_error
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_DATA    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MIN   = CNT_W'(MIN_HALF);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_HALF);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_HALF + 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

  // Synchroniser and edge-history flops.
  logic s1, s2, s3;
  logic line_edge, rise, fall;

  // Registered state and datapath.
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] h_q, h_d;
  logic [5:0]       pw_q, pw_d;
  logic             data_q, data_d;
  logic             strobe_q, strobe_d;
  logic             active_q, active_d;
  logic             error_q, error_d;

  // Thresholds derived from the measured half-bit length.
  logic [CNT_W-1:0] thr_mid;
  logic [CNT_W-1:0] thr_end;
  logic [CNT_W-1:0] cnt_inc_sat;

  // Bring the asynchronous line into the clk domain and keep one cycle of history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= in_line;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign line_edge = s2 ^ s3;
  assign rise      = s2 & ~s3;
  assign fall      = ~s2 & s3;

  // The mid-bit threshold sits halfway between a boundary edge (about H)
  // and the next mid-bit edge (about 2H), so +-H/2 of jitter is tolerated.
  assign thr_mid     = h_q + (h_q >> 1);
  assign thr_end     = h_q + (h_q << 1);
  assign cnt_inc_sat = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_ONE;

  // Register the FSM state, the interval counter and every output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      h_q      <= '0;
      pw_q     <= '0;
      data_q   <= 1'b0;
      strobe_q <= 1'b0;
      active_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      h_q      <= h_d;
      pw_q     <= pw_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      active_q <= active_d;
      error_q  <= error_d;
    end
  end

  // Next-state and next-output decisions. Strobe and error are single-cycle pulses.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    h_d      = h_q;
    pw_d     = pw_q;
    data_d   = data_q;
    strobe_d = 1'b0;
    active_d = active_q;
    error_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        active_d = 1'b0;
        if (rise) begin
          cnt_d   = CNT_ONE;
          state_d = ST_MEASURE;
        end
      end

      ST_MEASURE: begin
        if (fall) begin
          if ((cnt_q >= CNT_MIN) && (cnt_q <= CNT_MAX)) begin
            h_d      = cnt_q;
            pw_d     = 6'(cnt_q << 1);
            cnt_d    = CNT_ONE;
            active_d = 1'b1;
            state_d  = ST_DATA;
          end else begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end
        end else if (cnt_q >= CNT_LIMIT) begin
          // A start bit that stays high too long is rejected once. IDLE then
          // needs a fresh rise, so a stuck-high line cannot raise another error.
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_DATA: begin
        if (line_edge) begin
          // An edge takes priority over the timeout in the same cycle.
          if (cnt_q >= thr_mid) begin
            data_d   = s3;
            strobe_d = 1'b1;
            cnt_d    = CNT_ONE;
          end else begin
            cnt_d = cnt_inc_sat;
          end
        end else if (cnt_q >= thr_end) begin
          active_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_inc_sat;
        end
      end

      default: begin
        active_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  assign out_data       = data_q;
  assign out_strobe     = strobe_q;
  assign out_pulsewidth = pw_q;
  assign out_active     = active_q;
  assign out_error      = error_q;

endmodule

// File: tb/tb_manchester_decoder.sv
// Bench for manchester_decoder.
// Line waveforms are built as lists of transition times. A reference model
// then walks that list one transition at a time and predicts strobes, errors
// and out_active changes. A monitor records what the DUT actually does.
module tb_manchester_decoder;

  localparam int H_MIN = 2;
  localparam int H_MAX = 31;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_line = 1'b0;
  logic       out_data, out_strobe, out_active, out_error;
  logic [5:0] out_pulsewidth;

  manchester_decoder #(.CNT_W(7), .MIN_HALF(H_MIN), .MAX_HALF(H_MAX)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_line        (in_line),
    .out_data       (out_data),
    .out_strobe     (out_strobe),
    .out_pulsewidth (out_pulsewidth),
    .out_active     (out_active),
    .out_error      (out_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  // Observed and expected events: strobe/active entries are time*2+value.
  int   obs_strobe[$], obs_err[$], obs_act[$];
  int   exp_strobe[$], exp_err[$], exp_act[$];
  logic prev_act = 1'b0;
  int   m_pw = 0;
  int   m_data = 0;

  int   tr_t[$];
  logic tr_l[$];
  int   abs_t[$];
  logic abs_l[$];
  logic fbits[16];
  int   mid_flip = 0;
  int   frame_len = 0;
  int   base = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Record DUT events away from the active edge.
  always @(negedge clk) begin
    if (out_strobe === 1'b1) obs_strobe.push_back(cyc * 2 + int'(out_data));
    if (out_error === 1'b1) obs_err.push_back(cyc);
    if (out_active !== prev_act) begin
      obs_act.push_back(cyc * 2 + int'(out_active));
      prev_act = out_active;
    end
    if (rst_n) begin
      total++;
      assert (!(out_strobe === 1'b1 && out_error === 1'b1)) else begin
        bad++;
        $error("FAIL strobe_error_overlap observed=1 expected=0 at cyc=%0d", cyc);
      end
    end
  end

  function automatic int jit(input int jmode, input bit is_mid);
    if (jmode == 1) return int'($urandom_range(2, 0)) - 1;
    if (jmode == 2) begin
      if (!is_mid) return -1;
      mid_flip++;
      return (mid_flip % 2 == 1) ? 1 : -1;
    end
    return 0;
  endfunction

  // Start bit (h high, h low), then n data bits from fbits, then idle low.
  task automatic build_frame(input int h, input int n, input int jmode);
    logic prev;
    tr_t.delete();
    tr_l.delete();
    mid_flip = 0;
    tr_t.push_back(0); tr_l.push_back(1'b1);
    tr_t.push_back(h); tr_l.push_back(1'b0);
    prev = 1'b0;
    for (int i = 0; i < n; i++) begin
      int nb;
      nb = 2 * h * (i + 1);
      if (fbits[i] != prev) begin
        tr_t.push_back(nb + jit(jmode, 1'b0)); tr_l.push_back(fbits[i]);
      end
      tr_t.push_back(nb + h + jit(jmode, 1'b1)); tr_l.push_back(~fbits[i]);
      prev = ~fbits[i];
    end
    if (prev) begin
      tr_t.push_back(2 * h * (n + 1) + jit(jmode, 1'b0)); tr_l.push_back(1'b0);
    end
    frame_len = tr_t[tr_t.size() - 1] + 3 * h + 12;
  endtask

  // Drive the transition list, one cycle per loop pass; optional one-cycle reset.
  task automatic play(input int len, input int rst_at);
    int k;
    k = 0;
    abs_t.delete();
    abs_l.delete();
    @(posedge clk); #1;
    base = cyc;
    for (int c = 0; c < len; c++) begin
      while (k < tr_t.size() && tr_t[k] == c) begin
        in_line = tr_l[k];
        abs_t.push_back(base + tr_t[k]);
        abs_l.push_back(tr_l[k]);
        k++;
      end
      if (c == rst_at) rst_n = 1'b0;
      if (rst_at >= 0 && c == rst_at + 1) begin
        chk("midrst_strobe", int'(out_strobe), 0);
        chk("midrst_active", int'(out_active), 0);
        chk("midrst_error", int'(out_error), 0);
        chk("midrst_data", int'(out_data), 0);
        chk("midrst_pw", int'(out_pulsewidth), 0);
        rst_n = 1'b1;
      end
      @(posedge clk); #1;
    end
  endtask

  // Transition-level reference: thresholds applied to time since last accepted edge.
  task automatic model_run();
    int st, t_rise, last, hh, d;
    st = 0; t_rise = 0; last = 0; hh = 0;
    for (int i = 0; i < abs_t.size(); i++) begin
      int   t;
      logic lv;
      t = abs_t[i];
      lv = abs_l[i];
      if (st == 2 && t - last > 3 * hh) begin
        exp_act.push_back((last + 3 + 3 * hh) * 2);
        st = 0;
      end
      case (st)
        0: if (lv) begin st = 1; t_rise = t; end
        1: begin
          d = t - t_rise;
          if (d > H_MAX) begin exp_err.push_back(t_rise + 3 + H_MAX + 1); st = 0; end
          else if (d < H_MIN) begin exp_err.push_back(t + 3); st = 0; end
          else begin
            hh = d; m_pw = 2 * d; last = t; st = 2;
            exp_act.push_back((t + 3) * 2 + 1);
          end
        end
        default: begin
          d = t - last;
          if (d >= hh + hh / 2) begin
            exp_strobe.push_back((t + 3) * 2 + (lv ? 0 : 1));
            m_data = lv ? 0 : 1;
            last = t;
          end
        end
      endcase
    end
    if (st == 2) exp_act.push_back((last + 3 + 3 * hh) * 2);
    if (st == 1) exp_err.push_back(t_rise + 3 + H_MAX + 1);
  endtask

  task automatic chk_bits(input string tag, input int n);
    chk({tag, "_nbits"}, obs_strobe.size(), n);
    for (int i = 0; i < n && i < obs_strobe.size(); i++)
      chk({tag, "_bit"}, obs_strobe[i] % 2, int'(fbits[i]));
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_nstrobe"}, obs_strobe.size(), exp_strobe.size());
    for (int i = 0; i < obs_strobe.size() && i < exp_strobe.size(); i++)
      chk({tag, "_strobe"}, obs_strobe[i], exp_strobe[i]);
    chk({tag, "_nerr"}, obs_err.size(), exp_err.size());
    for (int i = 0; i < obs_err.size() && i < exp_err.size(); i++)
      chk({tag, "_err"}, obs_err[i], exp_err[i]);
    chk({tag, "_nact"}, obs_act.size(), exp_act.size());
    for (int i = 0; i < obs_act.size() && i < exp_act.size(); i++)
      chk({tag, "_act"}, obs_act[i], exp_act[i]);
    chk({tag, "_pw"}, int'(out_pulsewidth), m_pw);
    chk({tag, "_data"}, int'(out_data), m_data);
    chk({tag, "_idle"}, int'(out_active), 0);
    obs_strobe.delete(); obs_err.delete(); obs_act.delete();
    exp_strobe.delete(); exp_err.delete(); exp_act.delete();
  endtask

  initial begin
    // Reset state.
    rst_n = 1'b0;
    in_line = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", int'(out_data), 0);
    chk("rst_strobe", int'(out_strobe), 0);
    chk("rst_pw", int'(out_pulsewidth), 0);
    chk("rst_active", int'(out_active), 0);
    chk("rst_error", int'(out_error), 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // H=5, bits 1,0,1,1, then idle low until timeout.
    fbits[0] = 1'b1; fbits[1] = 1'b0; fbits[2] = 1'b1; fbits[3] = 1'b1;
    build_frame(5, 4, 0);
    play(frame_len, -1);
    model_run();
    chk("f1_pw10", int'(out_pulsewidth), 10);
    chk_bits("f1", 4);
    compare_all("f1");

    // Start bit high for a single cycle.
    tr_t.delete(); tr_l.delete();
    tr_t.push_back(0); tr_l.push_back(1'b1);
    tr_t.push_back(1); tr_l.push_back(1'b0);
    play(20, -1);
    model_run();
    chk("short_nerr", obs_err.size(), 1);
    compare_all("short");

    // Line stuck high for 40 cycles.
    tr_t.delete(); tr_l.delete();
    tr_t.push_back(0); tr_l.push_back(1'b1);
    tr_t.push_back(40); tr_l.push_back(1'b0);
    play(60, -1);
    model_run();
    chk("stuck_nerr", obs_err.size(), 1);
    compare_all("stuck");

    // H=5 with every data transition moved by one cycle.
    fbits[0] = 1'b0; fbits[1] = 1'b0; fbits[2] = 1'b1; fbits[3] = 1'b1; fbits[4] = 1'b0;
    build_frame(5, 5, 2);
    play(frame_len, -1);
    model_run();
    chk_bits("jit", 5);
    compare_all("jit");

    // Random half-periods, bit patterns and +-1 jitter.
    for (int r = 0; r < 6; r++) begin
      int h, n;
      h = int'($urandom_range(15, 6));
      n = int'($urandom_range(8, 1));
      for (int i = 0; i < n; i++) fbits[i] = 1'($urandom_range(1, 0));
      build_frame(h, n, 1);
      play(frame_len, -1);
      model_run();
      chk_bits("rnd", n);
      compare_all("rnd");
    end

    // Reset one cycle after the second strobe, while the frame is still active.
    fbits[0] = 1'b0; fbits[1] = 1'b1;
    build_frame(5, 2, 0);
    play(frame_len, 29);
    model_run();
    if (exp_act.size() > 0) exp_act.pop_back();
    exp_act.push_back((base + 30) * 2);
    m_pw = 0;
    m_data = 0;
    chk_bits("rstf", 2);
    compare_all("rstf");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
